// File: rtl/ti_sbox_layer_ctrl.sv
// ti_sbox_layer_ctrl: feeds a shared state nibble-by-nibble through an external TI S-box pipeline,
// stalling every stage whenever fresh remasking randomness is missing.
module ti_sbox_layer_ctrl #(
    parameter int NIBBLES = 16,
    parameter int SHARES  = 3,
    parameter int STAGES  = 2
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          start,
    input  logic [SHARES*4*NIBBLES-1:0]   state_in,
    output logic [SHARES*4*NIBBLES-1:0]   state_out,
    output logic                          busy,
    output logic                          done,
    input  logic                          rnd_valid,
    output logic                          rnd_ack,
    output logic                          sb_en,
    output logic [SHARES*4-1:0]           sb_in,
    input  logic [SHARES*4-1:0]           sb_out
);
    localparam int W  = SHARES * 4 * NIBBLES;
    localparam int CW = $clog2(NIBBLES + 1);
    localparam logic [CW-1:0] NIB = CW'(NIBBLES);

    typedef enum logic [1:0] {IDLE, RUN, FIN} fsm_t;

    fsm_t              fsm_q, fsm_d;
    logic [W-1:0]      st_q, st_d;
    logic [CW-1:0]     feed_q, feed_d, col_q, col_d;
    logic [STAGES-1:0] vpipe_q, vpipe_d;
    logic [STAGES:0]   vsh;
    logic              issue;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fsm_q   <= IDLE;
            st_q    <= '0;
            feed_q  <= '0;
            col_q   <= '0;
            vpipe_q <= '0;
        end else begin
            fsm_q   <= fsm_d;
            st_q    <= st_d;
            feed_q  <= feed_d;
            col_q   <= col_d;
            vpipe_q <= vpipe_d;
        end
    end

    always_comb begin
        fsm_d   = fsm_q;
        st_d    = st_q;
        feed_d  = feed_q;
        col_d   = col_q;
        vpipe_d = vpipe_q;
        sb_en   = 1'b0;
        done    = 1'b0;
        issue   = feed_q < NIB;
        vsh     = {vpipe_q, issue};
        case (fsm_q)
            IDLE: if (start) begin
                fsm_d   = RUN;
                st_d    = state_in;
                feed_d  = '0;
                col_d   = '0;
                vpipe_d = '0;
            end
            RUN: begin
                sb_en = rnd_valid;
                if (sb_en) begin
                    vpipe_d = vsh[STAGES-1:0];
                    feed_d  = issue ? feed_q + CW'(1) : feed_q;
                    // collect the oldest in-flight nibble into the same slot of every share
                    if (vpipe_q[STAGES-1]) begin
                        for (int s = 0; s < SHARES; s++)
                            st_d[s*4*NIBBLES + 4*int'(col_q) +: 4] = sb_out[4*s +: 4];
                        col_d = col_q + CW'(1);
                        fsm_d = (col_d == NIB) ? FIN : RUN;
                    end
                end
            end
            FIN: begin
                done  = 1'b1;
                fsm_d = IDLE;
            end
            default: fsm_d = IDLE;
        endcase
    end

    always_comb begin
        sb_in = '0;
        for (int s = 0; s < SHARES; s++)
            sb_in[4*s +: 4] = (feed_q == NIB) ? 4'h0 : st_q[s*4*NIBBLES + 4*int'(feed_q) +: 4];
    end

    assign state_out = st_q;
    assign busy      = fsm_q != IDLE;
    assign rnd_ack   = sb_en;
endmodule

// File: tb/tb_ti_sbox_layer_ctrl.sv
// tb_ti_sbox_layer_ctrl: directed checks of the TI S-box layer sequencer against an
// identity / XOR-A stand-in for the external S-box pipeline (STAGES 2, plus 1 and 4 instances).
module tb_ti_sbox_layer_ctrl;
    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         start = 1'b0, start_x = 1'b0, rnd_valid = 1'b1, mode = 1'b0;
    logic [191:0] state_in = '0;
    logic [191:0] so2, so1, so4;
    logic         busy2, busy1, busy4, done2, done1, done4, ack2, ack1, ack4, en2, en1, en4;
    logic [11:0]  in2, in1, in4, out2, out1, out4;
    logic [11:0]  m2 [2];
    logic [11:0]  m1 [1];
    logic [11:0]  m4 [4];
    logic [4:0]   pat = 5'b01001;
    int           npass = 0, ntot = 0;

    always #5 clk = ~clk;

    ti_sbox_layer_ctrl #(.STAGES(2)) dut (.clk(clk), .rst_n(rst_n), .start(start), .state_in(state_in),
        .state_out(so2), .busy(busy2), .done(done2), .rnd_valid(rnd_valid), .rnd_ack(ack2),
        .sb_en(en2), .sb_in(in2), .sb_out(out2));
    ti_sbox_layer_ctrl #(.STAGES(1)) dut1 (.clk(clk), .rst_n(rst_n), .start(start_x), .state_in(state_in),
        .state_out(so1), .busy(busy1), .done(done1), .rnd_valid(rnd_valid), .rnd_ack(ack1),
        .sb_en(en1), .sb_in(in1), .sb_out(out1));
    ti_sbox_layer_ctrl #(.STAGES(4)) dut4 (.clk(clk), .rst_n(rst_n), .start(start_x), .state_in(state_in),
        .state_out(so4), .busy(busy4), .done(done4), .rnd_valid(rnd_valid), .rnd_ack(ack4),
        .sb_en(en4), .sb_in(in4), .sb_out(out4));

    function automatic logic [11:0] xmap(input logic [11:0] x, input logic m);
        return m ? x ^ 12'hAAA : x;
    endfunction

    always @(posedge clk) if (en2) begin m2[0] <= xmap(in2, mode); m2[1] <= m2[0]; end
    always @(posedge clk) if (en1) m1[0] <= xmap(in1, mode);
    always @(posedge clk) if (en4) begin
        m4[0] <= xmap(in4, mode);
        for (int i = 1; i < 4; i++) m4[i] <= m4[i-1];
    end
    assign out2 = m2[1];
    assign out1 = m1[0];
    assign out4 = m4[3];

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic run_pass(input logic [191:0] v, input logic stray, input logic patt,
                            output int edges, output int en_cnt, output int lows, output int frozen_bad);
        logic [11:0]  prev_in;
        logic [191:0] prev_st;
        state_in = v;
        start = 1'b1;
        tick();
        start = 1'b0;
        edges = 0; en_cnt = 0; lows = 0; frozen_bad = 0;
        while (!done2 && edges < 100) begin
            rnd_valid = patt ? pat[edges % 5] : 1'b1;
            start = stray && (edges == 2 || edges == 9);
            #1;
            if (en2) en_cnt++;
            if (!rnd_valid) lows++;
            prev_in = in2;
            prev_st = so2;
            tick();
            edges++;
            if (!rnd_valid && (in2 !== prev_in || so2 !== prev_st)) frozen_bad++;
        end
        start = 1'b0;
        rnd_valid = 1'b1;
        #1;
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        rnd_valid = 1'b1;
        #2;
        ntot++; if (so2 !== '0) $display("FAIL rst_state: got %h want 0", so2); else npass++;
        ntot++; if (busy2 !== 1'b0) $display("FAIL rst_busy: got %b want 0", busy2); else npass++;
        ntot++; if (done2 !== 1'b0) $display("FAIL rst_done: got %b want 0", done2); else npass++;
        ntot++; if (en2 !== 1'b0) $display("FAIL rst_sb_en: got %b want 0", en2); else npass++;
        ntot++; if (ack2 !== 1'b0) $display("FAIL rst_ack: got %b want 0", ack2); else npass++;
        tick();
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_identity;
        logic [191:0] v;
        int e, n, l, f;
        mode = 1'b0;
        v = {$urandom(), $urandom(), $urandom(), $urandom(), $urandom(), $urandom()};
        run_pass(v, 1'b0, 1'b0, e, n, l, f);
        ntot++; if (e !== 18) $display("FAIL id_latency: got %0d want 18", e); else npass++;
        ntot++; if (done2 !== 1'b1) $display("FAIL id_done: got %b want 1", done2); else npass++;
        ntot++; if (busy2 !== 1'b1) $display("FAIL id_busy_done: got %b want 1", busy2); else npass++;
        ntot++; if (en2 !== 1'b0) $display("FAIL id_en_in_done: got %b want 0", en2); else npass++;
        ntot++; if (n !== 18) $display("FAIL id_en_cycles: got %0d want 18", n); else npass++;
        ntot++; if (so2 !== v) $display("FAIL id_state: got %h want %h", so2, v); else npass++;
        tick();
        ntot++; if (done2 !== 1'b0) $display("FAIL id_done_pulse: got %b want 0", done2); else npass++;
        ntot++; if (busy2 !== 1'b0) $display("FAIL id_idle: got %b want 0", busy2); else npass++;
        ntot++; if (so2 !== v) $display("FAIL id_state_hold: got %h want %h", so2, v); else npass++;
    endtask

    task automatic test_map;
        logic [191:0] v, x, q;
        int e, n, l, f;
        mode = 1'b1;
        v = 192'h0123456789ABCDEF_FEDCBA9876543210_00112233CAFEBABE;
        x = 192'hAB89EFCD23016745_54761032DCFE98BA_AABB889960541014;
        run_pass(v, 1'b0, 1'b0, e, n, l, f);
        q = so2;
        ntot++; if (e !== 18) $display("FAIL map_latency: got %0d want 18", e); else npass++;
        ntot++; if (q !== x) $display("FAIL map_state: got %h want %h", q, x); else npass++;
        ntot++; if (q[191:188] !== 4'hA) $display("FAIL map_top_nibble: got %h want a", q[191:188]); else npass++;
        mode = 1'b0;
        tick();
    endtask

    task automatic test_stall;
        logic [191:0] v;
        int e, n, l, f;
        v = 192'h5A5A_1234_8765_F00D_BEEF_0F0F_C3C3_9999_0000_FFFF_1357_2468;
        run_pass(v, 1'b0, 1'b1, e, n, l, f);
        ntot++; if (e !== 44) $display("FAIL stall_latency: got %0d want 44", e); else npass++;
        ntot++; if (l !== 26) $display("FAIL stall_lows: got %0d want 26", l); else npass++;
        ntot++; if (n !== 18) $display("FAIL stall_en_cycles: got %0d want 18", n); else npass++;
        ntot++; if (f !== 0) $display("FAIL stall_frozen: got %0d changes want 0", f); else npass++;
        ntot++; if (so2 !== v) $display("FAIL stall_state: got %h want %h", so2, v); else npass++;
        tick();
    endtask

    task automatic test_back_to_back;
        logic [191:0] v, w;
        int e, n, l, f;
        v = 192'h1111_2222_3333_4444_5555_6666_7777_8888_9999_AAAA_BBBB_CCCC;
        w = 192'hFEDC_BA98_7654_3210_0F1E_2D3C_4B5A_6978_8796_A5B4_C3D2_E1F0;
        run_pass(v, 1'b1, 1'b0, e, n, l, f);
        ntot++; if (e !== 18) $display("FAIL b2b_stray_latency: got %0d want 18", e); else npass++;
        ntot++; if (so2 !== v) $display("FAIL b2b_state1: got %h want %h", so2, v); else npass++;
        state_in = w;
        start = 1'b1;
        tick();
        start = 1'b0;
        ntot++; if (done2 !== 1'b0) $display("FAIL b2b_single_done: got %b want 0", done2); else npass++;
        ntot++; if (busy2 !== 1'b0) $display("FAIL b2b_start_in_done: got %b want 0", busy2); else npass++;
        run_pass(w, 1'b0, 1'b0, e, n, l, f);
        ntot++; if (e !== 18) $display("FAIL b2b_latency2: got %0d want 18", e); else npass++;
        ntot++; if (so2 !== w) $display("FAIL b2b_state2: got %h want %h", so2, w); else npass++;
        tick();
    endtask

    task automatic test_reset_mid;
        logic [191:0] v, w;
        int e, n, l, f;
        v = 192'hDEAD_BEEF_CAFE_F00D_0123_4567_89AB_CDEF_1357_9BDF_2468_ACE0;
        w = 192'h0F0F_F0F0_3C3C_C3C3_A5A5_5A5A_1248_8421_7777_EEEE_1010_0101;
        state_in = v;
        start = 1'b1;
        tick();
        start = 1'b0;
        repeat (6) tick();
        #2;
        rst_n = 1'b0;
        #1;
        ntot++; if (busy2 !== 1'b0) $display("FAIL mid_rst_busy: got %b want 0", busy2); else npass++;
        ntot++; if (done2 !== 1'b0) $display("FAIL mid_rst_done: got %b want 0", done2); else npass++;
        ntot++; if (en2 !== 1'b0) $display("FAIL mid_rst_sb_en: got %b want 0", en2); else npass++;
        ntot++; if (so2 !== '0) $display("FAIL mid_rst_state: got %h want 0", so2); else npass++;
        tick();
        rst_n = 1'b1;
        tick();
        run_pass(w, 1'b0, 1'b0, e, n, l, f);
        ntot++; if (e !== 18) $display("FAIL mid_rst_latency: got %0d want 18", e); else npass++;
        ntot++; if (so2 !== w) $display("FAIL mid_rst_state2: got %h want %h", so2, w); else npass++;
        tick();
    endtask

    task automatic test_stages;
        logic [191:0] v;
        int e, d1, d4;
        v = 192'h8BADF00D_13579BDF_02468ACE_FFFF0000_12345678_9ABCDEF0;
        mode = 1'b0;
        rnd_valid = 1'b1;
        state_in = v;
        start_x = 1'b1;
        tick();
        start_x = 1'b0;
        e = 0; d1 = -1; d4 = -1;
        while ((d1 < 0 || d4 < 0) && e < 40) begin
            tick();
            e++;
            if (done1 && d1 < 0) d1 = e;
            if (done4 && d4 < 0) d4 = e;
        end
        ntot++; if (d1 !== 17) $display("FAIL st1_latency: got %0d want 17", d1); else npass++;
        ntot++; if (d4 !== 20) $display("FAIL st4_latency: got %0d want 20", d4); else npass++;
        ntot++; if (so1 !== v) $display("FAIL st1_state: got %h want %h", so1, v); else npass++;
        ntot++; if (so4 !== v) $display("FAIL st4_state: got %h want %h", so4, v); else npass++;
    endtask

    initial begin
        test_reset();
        test_identity();
        test_map();
        test_stall();
        test_back_to_back();
        test_reset_mid();
        test_stages();
        $display("%0d/%0d checks passed", npass, ntot);
        $finish;
    end
endmodule

// File: doc/ti_sbox_layer_ctrl.md
Name: ti_sbox_layer_ctrl

Overview:
Sequencer that applies a shared threshold-implementation (TI) 4-bit S-box, one nibble at a time, across a full shared cipher state.
- The TI S-box datapath is external: the stage-decomposed component functions plus their inter-stage registers, all gated by one enable.
- This block holds the shared state, feeds nibbles in, tracks in-flight nibbles and writes results back.
- It stalls the whole pipeline whenever fresh remasking randomness is unavailable, so glitch-separated stages never advance on stale masks.

Parameters:
NIBBLES, 16, number of 4-bit nibbles per share (64-bit state)
SHARES, 3, number of TI shares
STAGES, 2, register depth of the external TI S-box pipeline (>=1)

Ports:
clk  input  1  clock, rising edge
rst_n  input  1  asynchronous active-low reset
start  input  1  begin a layer pass; sampled only in IDLE
state_in  input  SHARES*4*NIBBLES  shared state; share s at bits [s*4*NIBBLES +: 4*NIBBLES]
state_out  output  SHARES*4*NIBBLES  internal shared state register
busy  output  1  high in RUN and DONE
done  output  1  one-cycle pulse, pass complete, state_out valid
rnd_valid  input  1  fresh randomness present for the external stages this cycle
rnd_ack  output  1  randomness consumed this cycle (equals sb_en)
sb_en  output  1  enable for all external S-box stage registers
sb_in  output  SHARES*4  current nibble of each share; share s at [4s+3:4s]
sb_out  input  SHARES*4  S-box pipeline result, same packing, valid STAGES enabled cycles after issue

Behaviour:
- Single clock `clk`; reset is asynchronous and active-low on `rst_n`.
- Reset values: FSM=IDLE, state register=0, feed_cnt=0, col_cnt=0, vpipe=0. So state_out=0, busy=0, done=0, sb_en=0, rnd_ack=0.
- Nibble i of share s is state bits [s*4*NIBBLES + 4i +: 4].
- FSM states:
  - IDLE: on start=1, load state_in into the state register, clear both counters and vpipe, go to RUN. Otherwise hold.
  - RUN: sb_en = rnd_valid. While sb_en=0 nothing changes (counters, vpipe and state all frozen).
  - On each cycle with sb_en=1:
    - issue: if feed_cnt<NIBBLES, shift a 1 into vpipe[0] and increment feed_cnt; otherwise shift in 0.
    - vpipe is a STAGES-bit shift register.
    - collect: if vpipe[STAGES-1]=1 before the shift, write sb_out into nibble col_cnt of every share and increment col_cnt.
  - When a collect makes col_cnt==NIBBLES, go to DONE.
  - DONE: done=1 and sb_en=0 for exactly one cycle, then IDLE.
- sb_in is combinational: nibble feed_cnt of each share from the state register. When feed_cnt==NIBBLES it is driven 0.
- Issue and collect of different nibbles may occur in the same cycle. A nibble is never read after its own write-back, because issue order equals collect order and feed_cnt >= col_cnt.
- Latency with rnd_valid held at 1: done is high in the cycle after the (NIBBLES+STAGES)-th rising edge following the start-sampling edge (18 edges for the defaults). Each RUN cycle with rnd_valid=0 adds exactly one cycle.
- start in RUN or DONE is ignored, with no queuing. start in the cycle after done is accepted.
- Reset asserted mid-pass aborts immediately to the reset values. No partial-result hold.
- Counters are sized clog2(NIBBLES+1) bits. There is no wrap-around; col_cnt saturates at NIBBLES by construction.
- state_out is stable outside RUN. The caller must not rely on it during RUN.

Test Plan:
- Identity model (sb_out = sb_in delayed STAGES enabled cycles), rnd_valid=1, state_in=random 192-bit: done after 18 edges, state_out==state_in, sb_en high for exactly 18 RUN cycles.
- Nibble-map model (each share nibble XOR 4'hA per share, i.e. XOR 4'hA on the unshared value for odd SHARES): state_out == state_in with every share nibble XOR 4'hA. Nibble 15 of share 2 lands at bits [191:188].
- rnd_valid pattern 1,0,0,1,0 repeating during RUN: done delayed by exactly the number of low cycles. Counters and vpipe frozen on low cycles. Results match the identity case.
- start pulsed at cycles 3 and 10 of RUN and in the DONE cycle: ignored; only one done pulse. start the cycle after done: new pass begins.
- rst_n low at RUN cycle 7: busy, done, sb_en and state_out go to 0 asynchronously. After release, a fresh start completes normally in 18 edges.
- STAGES=1 and STAGES=4 builds, identity model: done after NIBBLES+STAGES edges (17 and 20), state_out==state_in.
